// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 8-bit adder among NUM_REQ requesters, one op in flight.
// Accept-to-response 2+ADD_LATENCY cycles; result held in RESP until the winner asserts rsp_ready.
module add_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*8-1:0]       req_ip1,
  input  logic [NUM_REQ*8-1:0]       req_ip2,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [8:0]                 rsp_out,
  output logic [7:0]                 add_ip1,
  output logic [7:0]                 add_ip2,
  input  logic [8:0]                 add_out,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int                 IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0]       NR  = (IDW+1)'(NUM_REQ);
  localparam logic [2:0]         LAT = 3'(ADD_LATENCY);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [2:0]     cnt;
  logic [7:0]     ip1_arr [NUM_REQ];
  logic [7:0]     ip2_arr [NUM_REQ];
  logic           pick_vld;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   sum_w;
  logic           accept;
  logic           capture;
  logic           release_rsp;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ip1_arr[g] = req_ip1[8*g +: 8];
    assign ip2_arr[g] = req_ip2[8*g +: 8];
  end

  // Search upward from ptr+1 with wrap; the last winner is naturally visited last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    sum_w    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_w = {1'b0, ptr} + (IDW+1)'(k);
      if (sum_w >= NR) sum_w = sum_w - NR;
      if (!pick_vld && req_valid[sum_w[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = sum_w[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (rst && pick_vld) begin
          req_ready = ONE << pick_id;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = ONE << grant_id;
        if (rsp_ready[grant_id]) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= IDW'(NUM_REQ-1);
      grant_id <= '0;
      cnt      <= 3'd0;
      add_ip1  <= 8'd0;
      add_ip2  <= 8'd0;
      rsp_out  <= 9'd0;
    end else begin
      if (accept) begin
        add_ip1  <= ip1_arr[pick_id];
        add_ip2  <= ip2_arr[pick_id];
        grant_id <= pick_id;
        cnt      <= LAT;
      end else if (state == EXEC && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (capture)     rsp_out <= add_out;
      if (release_rsp) ptr     <= grant_id;
    end
  end

  assign busy = (state != IDLE);

endmodule
